usart_tx_arbiter: RTL and testbench

// - Shares one usart_tx transmitter between NUM_REQ byte producers (console, debug, status).
// - Round-robin arbitration, one byte per grant. Sequences the transmitter's latch/ready/done handshake.
// - Holds tx_data stable for the whole frame. Detects a transmitter that never accepts a byte (timeout).
// - Runs on the transmitter's bit clock.
//

---
 rtl/usart_pkg.sv | 31 +++
 rtl/rr_pick.sv | 34 +++
 rtl/usart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_usart_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// rtl/usart_pkg.sv - shared types and constants for the usart transmit path
//
// Purpose: arbiter state encoding, frame length and grant index width,
//          plus the round-robin pointer advance helper.
// Ports:   none (package)
package usart_pkg;

  typedef enum logic [1:0] {
    USART_ARB_IDLE       = 2'd0,
    USART_ARB_LATCH      = 2'd1,
    USART_ARB_WAIT_START = 2'd2,
    USART_ARB_WAIT_DONE  = 2'd3
  } usart_arb_state_e;

  // start bit + 8 data bits + stop bit
  localparam int USART_FRAME_BITS = 10;

  localparam int USART_GRANT_W = 3;

  // Pointer position just past idx, wrapping at n.
  function automatic logic [USART_GRANT_W-1:0] usart_rr_next(
    input logic [USART_GRANT_W-1:0] idx,
    input int                       n
  );
    if (int'(idx) >= n - 1) begin
      return '0;
    end
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority select
//
// Purpose: returns the first set bit of valid_i found by searching upward
//          from ptr_i and wrapping modulo N.
// Ports:
//   valid_i  in   N      request vector
//   ptr_i    in   IDX_W  search start position (must be < N)
//   found_o  out  1      at least one request set
//   idx_o    out  IDX_W  selected index (0 when nothing found)
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    int j;
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found_o && valid_i[j]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/usart_tx_arbiter.sv
// rtl/usart_tx_arbiter.sv - round-robin sharing of one usart_tx among byte producers
//
// Purpose: grants one byte per frame to NUM_REQ producers in round-robin order,
//          drives the transmitter latch/ready/done handshake, holds tx_data for
//          the whole frame and flags a transmitter that never accepts (sticky).
// Ports:
//   bit_clock_x1  in   1          clock shared with usart_tx
//   reset_n       in   1          synchronous active-low reset
//   req_valid     in   NUM_REQ    requester i has a byte pending
//   req_data      in   8*NUM_REQ  byte i at [8*i+7:8*i]
//   req_ack       out  NUM_REQ    one-cycle accept pulse per requester
//   tx_data       out  8          byte to usart_tx
//   tx_latch      out  1          load request to usart_tx
//   tx_ready      in   1          usart_tx accept pulse
//   tx_done       in   1          usart_tx line idle
//   busy          out  1          arbiter not in IDLE
//   grant_idx     out  3          current/last granted requester
//   timeout_err   out  1          sticky accept-timeout flag
module usart_tx_arbiter
  import usart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ACCEPT_TIMEOUT = 15
) (
  input  logic                     bit_clock_x1,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [8*NUM_REQ-1:0]     req_data,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [7:0]               tx_data,
  output logic                     tx_latch,
  input  logic                     tx_ready,
  input  logic                     tx_done,
  output logic                     busy,
  output logic [USART_GRANT_W-1:0] grant_idx,
  output logic                     timeout_err
);

  localparam logic [7:0] LATCH_LAST = 8'(ACCEPT_TIMEOUT - 1);
  // tx_latch must stay low this many cycles before it may rise again, so the
  // transmitter's two-stage latch synchroniser drains between frames.
  localparam logic [1:0] MIN_LOW = 2'd3;

  usart_arb_state_e         state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [USART_GRANT_W-1:0] rr_q, rr_d;
  logic [USART_GRANT_W-1:0] grant_q, grant_d;
  logic [7:0]               data_q, data_d;
  logic                     latch_q, latch_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic                     terr_q, terr_d;
  logic [1:0]               low_q, low_d;

  logic                     pick_found;
  logic [USART_GRANT_W-1:0] pick_idx;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (USART_GRANT_W)
  ) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    data_d  = data_q;
    latch_d = latch_q;
    ack_d   = '0;
    terr_d  = terr_q;

    unique case (state_q)
      USART_ARB_IDLE: begin
        cnt_d = '0;
        if (pick_found && (low_q == MIN_LOW)) begin
          grant_d = pick_idx;
          data_d  = req_data[8*int'(pick_idx) +: 8];
          latch_d = 1'b1;
          state_d = USART_ARB_LATCH;
        end
      end
      USART_ARB_LATCH: begin
        if (tx_ready) begin
          latch_d = 1'b0;
          ack_d   = NUM_REQ'(1) << grant_q;
          rr_d    = usart_rr_next(grant_q, NUM_REQ);
          cnt_d   = '0;
          state_d = USART_ARB_WAIT_START;
        end else if (cnt_q == LATCH_LAST) begin
          // Abort without moving the pointer: the same requester wins next.
          latch_d = 1'b0;
          terr_d  = 1'b1;
          cnt_d   = '0;
          state_d = USART_ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      USART_ARB_WAIT_START: begin
        // A done that is still high after two cycles is treated as a late
        // update; WAIT_DONE then sorts out whether the frame has finished.
        if (!tx_done || (cnt_q == 8'd1)) begin
          cnt_d   = '0;
          state_d = USART_ARB_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      USART_ARB_WAIT_DONE: begin
        if (tx_done) begin
          state_d = USART_ARB_IDLE;
        end
      end
      default: state_d = USART_ARB_IDLE;
    endcase

    if (latch_d) begin
      low_d = '0;
    end else if (low_q != MIN_LOW) begin
      low_d = low_q + 2'd1;
    end else begin
      low_d = low_q;
    end
  end

  always_ff @(posedge bit_clock_x1) begin
    if (!reset_n) begin
      state_q <= USART_ARB_IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      data_q  <= '0;
      latch_q <= 1'b0;
      ack_q   <= '0;
      terr_q  <= 1'b0;
      // Start saturated so a request right after reset is latched next cycle.
      low_q   <= MIN_LOW;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      latch_q <= latch_d;
      ack_q   <= ack_d;
      terr_q  <= terr_d;
      low_q   <= low_d;
    end
  end

  assign req_ack     = ack_q;
  assign tx_data     = data_q;
  assign tx_latch    = latch_q;
  assign busy        = (state_q != USART_ARB_IDLE);
  assign grant_idx   = grant_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// tb/tb_usart_tx_arbiter.sv - directed bench for usart_tx_arbiter with a usart_tx model
module tb_usart_tx_arbiter;
  import usart_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ack;
  logic [7:0]  tx_data;
  logic        tx_latch;
  logic        tx_ready;
  logic        tx_done;
  logic        busy;
  logic [2:0]  grant_idx;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  usart_tx_arbiter #(.NUM_REQ(4), .ACCEPT_TIMEOUT(15)) dut (
    .bit_clock_x1 (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ack      (req_ack),
    .tx_data      (tx_data),
    .tx_latch     (tx_latch),
    .tx_ready     (tx_ready),
    .tx_done      (tx_done),
    .busy         (busy),
    .grant_idx    (grant_idx),
    .timeout_err  (timeout_err)
  );

  // usart_tx model: 2-stage latch sync, edge detect, ready pulse, 10-bit shift
  logic       s1 = 0, s2 = 0, s3 = 0;
  logic       rdy_q = 0;
  logic       block_ready = 0;
  logic       shifting = 0;
  logic [9:0] frame = 10'h3FF;
  int         bitn = 0;
  logic       tx_pin = 1;
  logic       done_q = 1;
  assign tx_ready = rdy_q;
  assign tx_done  = done_q;

  always @(posedge clk) begin
    s1 <= tx_latch; s2 <= s1; s3 <= s2;
    rdy_q <= 1'b0;
    if (shifting) begin
      if (bitn == USART_FRAME_BITS - 1) begin
        shifting <= 1'b0; done_q <= 1'b1; tx_pin <= 1'b1;
      end else begin
        bitn <= bitn + 1; tx_pin <= frame[bitn+1];
      end
    end else if (s2 && !s3 && !block_ready) begin
      rdy_q <= 1'b1; frame <= {1'b1, tx_data, 1'b0}; bitn <= 0;
      shifting <= 1'b1; done_q <= 1'b0; tx_pin <= 1'b0;
    end
  end

  // line and handshake monitor
  logic [9:0] cur = '0;
  logic [9:0] last_bits = '0;
  int         nb = 0;
  logic [7:0] sent[$];
  int         frame_err = 0;
  int         rises = 0, gap = 0, gap_viol = 0, busy_cycles = 0;
  logic       prev_latch = 0;
  int         ack_cnt[4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    if (!tx_done) begin
      cur[nb] = tx_pin;
      nb = nb + 1;
      if (nb == USART_FRAME_BITS) begin
        if (cur[0] !== 1'b0 || cur[9] !== 1'b1) frame_err = frame_err + 1;
        sent.push_back(cur[8:1]);
        last_bits = cur;
        nb = 0;
      end
    end
    if (tx_latch) begin
      if (!prev_latch) begin
        rises = rises + 1;
        if (rises > 1 && gap < 3) gap_viol = gap_viol + 1;
      end
      gap = 0;
    end else begin
      gap = gap + 1;
    end
    prev_latch = tx_latch;
    for (int i = 0; i < 4; i++) if (req_ack[i]) ack_cnt[i] = ack_cnt[i] + 1;
    if (busy) busy_cycles = busy_cycles + 1;
  end

  // requester behaviour: drop valid on ack, or present a reload byte
  int         reload[4] = '{0, 0, 0, 0};
  logic [7:0] reload_data[4];

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (req_ack[i]) begin
        if (reload[i] > 0) begin
          reload[i] = reload[i] - 1;
          req_data[8*i +: 8] = reload_data[i];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; req_valid = '0; block_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // run until all requests are acked and the arbiter is idle; returns 1 on success
  task automatic drain(input int bound, output bit ok);
    ok = 0;
    for (int k = 0; k < bound; k++) begin
      step();
      if (req_valid == 4'h0 && !busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({busy, tx_latch, req_ack, timeout_err} !== 7'h0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {busy, tx_latch, req_ack, timeout_err});
    end
    total++;
    if ({grant_idx, tx_data} !== 11'h0) begin
      bad++; $display("FAIL reset_data: got grant=%0d data=%h want 0/00", grant_idx, tx_data);
    end
  endtask

  task automatic test_single();
    int s, a1, lat;
    bit ok;
    do_reset();
    s = sent.size(); a1 = ack_cnt[1];
    req_data[15:8] = 8'hA5; req_valid = 4'b0010;
    step();
    total++;
    if (tx_latch !== 1'b1 || grant_idx !== 3'd1 || tx_data !== 8'hA5) begin
      bad++; $display("FAIL single_latch: got latch=%b grant=%0d data=%h want 1/1/a5", tx_latch, grant_idx, tx_data);
    end
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      step(); lat++;
      if (req_ack[1]) break;
    end
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL single_ack_latency: got %0d want 4", lat);
    end
    drain(60, ok);
    total++;
    if (!ok || tx_done !== 1'b1) begin
      bad++; $display("FAIL single_idle: got ok=%0d done=%b want 1/1", ok, tx_done);
    end
    total++;
    if (sent.size() != s + 1 || last_bits !== 10'b1101001010 || frame_err != 0) begin
      bad++; $display("FAIL single_frame: got n=%0d bits=%b ferr=%0d want 1/1101001010/0", sent.size() - s, last_bits, frame_err);
    end
    total++;
    if (ack_cnt[1] - a1 != 1) begin
      bad++; $display("FAIL single_ack_count: got %0d want 1", ack_cnt[1] - a1);
    end
  endtask

  task automatic test_all_four();
    int s, r, g;
    int a[4];
    logic [31:0] got;
    bit ok;
    do_reset();
    s = sent.size(); r = rises; g = gap_viol;
    for (int i = 0; i < 4; i++) a[i] = ack_cnt[i];
    req_data = 32'h13121110; req_valid = 4'hF;
    drain(300, ok);
    total++;
    if (!ok || sent.size() != s + 4) begin
      bad++; $display("FAIL all4_count: got ok=%0d n=%0d want 1/4", ok, sent.size() - s);
    end else begin
      got = {sent[s+3], sent[s+2], sent[s+1], sent[s]};
      total++;
      if (got !== 32'h13121110) begin
        bad++; $display("FAIL all4_order: got %h want 13121110", got);
      end
    end
    total++;
    if (ack_cnt[0]-a[0] != 1 || ack_cnt[1]-a[1] != 1 || ack_cnt[2]-a[2] != 1 || ack_cnt[3]-a[3] != 1) begin
      bad++; $display("FAIL all4_acks: got %0d %0d %0d %0d want 1 each", ack_cnt[0]-a[0], ack_cnt[1]-a[1], ack_cnt[2]-a[2], ack_cnt[3]-a[3]);
    end
    total++;
    if (rises - r != 4 || gap_viol != g) begin
      bad++; $display("FAIL all4_latch: got rises=%0d gapviol=%0d want 4/0", rises - r, gap_viol - g);
    end
  endtask

  task automatic test_reassert();
    int s, a0, a2;
    logic [23:0] got;
    bit ok;
    do_reset();
    s = sent.size(); a0 = ack_cnt[0]; a2 = ack_cnt[2];
    req_data[7:0] = 8'h20; req_data[23:16] = 8'h2A;
    reload[0] = 1; reload_data[0] = 8'h22;
    req_valid = 4'b0101;
    drain(300, ok);
    total++;
    if (!ok || sent.size() != s + 3) begin
      bad++; $display("FAIL reassert_count: got ok=%0d n=%0d want 1/3", ok, sent.size() - s);
    end else begin
      got = {sent[s+2], sent[s+1], sent[s]};
      total++;
      if (got !== 24'h222A20) begin
        bad++; $display("FAIL reassert_order: got %h want 222a20", got);
      end
    end
    total++;
    if (ack_cnt[0] - a0 != 2 || ack_cnt[2] - a2 != 1) begin
      bad++; $display("FAIL reassert_acks: got %0d/%0d want 2/1", ack_cnt[0] - a0, ack_cnt[2] - a2);
    end
  endtask

  task automatic test_timeout();
    int hi, lo, s, a3;
    bit ok;
    do_reset();
    s = sent.size(); a3 = ack_cnt[3];
    block_ready = 1;
    req_data[31:24] = 8'h5C; req_valid = 4'b1000;
    step();
    hi = tx_latch ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!tx_latch) break;
      hi++;
    end
    total++;
    if (hi != 15) begin
      bad++; $display("FAIL timeout_latch_cycles: got %0d want 15", hi);
    end
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || ack_cnt[3] != a3) begin
      bad++; $display("FAIL timeout_abort: got err=%b busy=%b acks=%0d want 1/0/0", timeout_err, busy, ack_cnt[3] - a3);
    end
    block_ready = 0;
    lo = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tx_latch) break;
      lo++;
    end
    total++;
    if (!tx_latch || lo + 1 < 3 || grant_idx !== 3'd3 || tx_data !== 8'h5C) begin
      bad++; $display("FAIL timeout_retry: got latch=%b low=%0d grant=%0d data=%h want 1/>=3/3/5c", tx_latch, lo + 1, grant_idx, tx_data);
    end
    drain(80, ok);
    total++;
    if (!ok || sent.size() != s + 1 || ack_cnt[3] - a3 != 1 || timeout_err !== 1'b1) begin
      bad++; $display("FAIL timeout_recover: got ok=%0d n=%0d acks=%0d err=%b want 1/1/1/1", ok, sent.size() - s, ack_cnt[3] - a3, timeout_err);
    end else begin
      total++;
      if (sent[s] !== 8'h5C) begin
        bad++; $display("FAIL timeout_byte: got %h want 5c", sent[s]);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    int s, r;
    do_reset();
    s = sent.size(); r = rises;
    req_data[23:16] = 8'h3C; req_valid = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      step();
      if (req_ack[2]) break;
    end
    repeat (3) step();
    total++;
    if (busy !== 1'b1 || tx_done !== 1'b0) begin
      bad++; $display("FAIL rif_pre: got busy=%b done=%b want 1/0", busy, tx_done);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || tx_latch !== 1'b0 || req_ack !== 4'h0) begin
      bad++; $display("FAIL rif_reset: got busy=%b latch=%b ack=%b want 0/0/0000", busy, tx_latch, req_ack);
    end
    reset_n = 1'b1;
    repeat (20) step();
    total++;
    if (sent.size() != s + 1 || rises - r != 1 || tx_done !== 1'b1) begin
      bad++; $display("FAIL rif_complete: got n=%0d rises=%0d done=%b want 1/1/1", sent.size() - s, rises - r, tx_done);
    end else begin
      total++;
      if (sent[s] !== 8'h3C) begin
        bad++; $display("FAIL rif_byte: got %h want 3c", sent[s]);
      end
    end
  endtask

  task automatic test_idle();
    int r, b;
    do_reset();
    r = rises; b = busy_cycles;
    repeat (100) step();
    total++;
    if (rises != r || busy_cycles != b) begin
      bad++; $display("FAIL idle_quiet: got rises=%0d busy=%0d want 0/0", rises - r, busy_cycles - b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_reassert();
    test_timeout();
    test_reset_in_flight();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
